// File: rtl/lsu_dcache_arb_pkg.sv
// ============================================================================
// Module      : lsu_arb_pkg
// Description : Shared encodings for the LSU dcache request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HOLD      = 2'd1,
      WAIT_RESP = 2'd2,
      DRAIN     = 2'd3
   } arb_state_e;

   localparam logic LSU_OP_LOAD  = 1'b0;
   localparam logic LSU_OP_STORE = 1'b1;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

endpackage

`default_nettype wire

// File: rtl/lsu_dcache_arb_starve_ctr.sv
// ============================================================================
// Module      : lsu_arb_starve_ctr
// Description : Saturating count of arbitrations lost by the store path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_arb_starve_ctr #(
   parameter int STARVE_LIMIT = 4,
   parameter int STARVE_CNT_W = 3
) (
   input  logic clk,
   input  logic rstn,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam logic [STARVE_CNT_W-1:0] C_LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

   logic [STARVE_CNT_W-1:0] r_cnt;

   // Clear wins over increment so a store grant always restarts the window.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc && !sat) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign sat = (r_cnt == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/lsu_dcache_arb.sv
// ============================================================================
// Module      : lsu_dcache_arb
// Description : Shares the dcache port between the load pipe and store commit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_dcache_arb
   import lsu_arb_pkg::*;
#(
   parameter int VIRTUAL_ADDR_LEN = 39,
   parameter int XLEN             = 64,
   parameter int STARVE_LIMIT     = 4,
   parameter int STARVE_CNT_W     = 3
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        flush_i,
   input  logic                        ld_req_valid_i,
   output logic                        ld_req_ready_o,
   input  logic [1:0]                  ld_req_size_i,
   input  logic [VIRTUAL_ADDR_LEN-1:0] ld_req_addr_i,
   output logic                        ld_resp_valid_o,
   output logic [XLEN-1:0]             ld_resp_data_o,
   input  logic                        st_req_valid_i,
   output logic                        st_req_ready_o,
   input  logic [1:0]                  st_req_size_i,
   input  logic [VIRTUAL_ADDR_LEN-1:0] st_req_addr_i,
   input  logic [XLEN-1:0]             st_req_data_i,
   output logic                        req_valid_o,
   input  logic                        req_ready_i,
   output logic                        req_opcode_o,
   output logic [1:0]                  req_size_o,
   output logic [VIRTUAL_ADDR_LEN-1:0] req_addr_o,
   output logic [XLEN-1:0]             req_data_o,
   input  logic                        resp_valid_i,
   input  logic [XLEN-1:0]             resp_data_i,
   output logic                        resp_ready_o,
   output logic                        busy_o
);

   arb_state_e r_state;
   logic       r_grant;

   logic w_idle;
   logic w_wait;
   logic w_ld_elig;
   logic w_st_win;
   logic w_win_valid;
   logic w_win_op;
   logic w_op;
   logic w_req_valid;
   logic w_accept;
   logic w_sat;
   logic w_starve_inc;

   assign w_idle      = (r_state == IDLE);
   assign w_wait      = (r_state == WAIT_RESP);
   assign w_ld_elig   = ld_req_valid_i & ~flush_i;
   assign w_st_win    = st_req_valid_i & (~w_ld_elig | w_sat);
   assign w_win_valid = w_ld_elig | st_req_valid_i;
   assign w_win_op    = w_st_win ? LSU_OP_STORE : LSU_OP_LOAD;

   // IDLE issues straight from the arbitration result; HOLD replays the latched grant.
   assign w_op = w_idle ? w_win_op : r_grant;

   always_comb begin
      w_req_valid = 1'b0;
      case (r_state)
         IDLE:    w_req_valid = w_win_valid;
         HOLD:    w_req_valid = ~(flush_i & (r_grant == LSU_OP_LOAD));
         default: w_req_valid = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_grant <= LSU_OP_LOAD;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_win_valid) begin
                  if (req_ready_i) begin
                     if (w_win_op == LSU_OP_LOAD) r_state <= WAIT_RESP;
                  end else begin
                     r_state <= HOLD;
                     r_grant <= w_win_op;
                  end
               end
            end
            HOLD: begin
               if (flush_i && (r_grant == LSU_OP_LOAD)) begin
                  r_state <= IDLE;
               end else if (req_ready_i) begin
                  r_state <= (r_grant == LSU_OP_STORE) ? IDLE : WAIT_RESP;
               end
            end
            WAIT_RESP: begin
               if (resp_valid_i)  r_state <= IDLE;
               else if (flush_i)  r_state <= DRAIN;
            end
            DRAIN: begin
               if (resp_valid_i)  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_starve_inc = w_idle & st_req_valid_i & ~w_st_win;

   lsu_arb_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .STARVE_CNT_W (STARVE_CNT_W)
   ) u_starve_ctr (
      .clk  (clk),
      .rstn (rstn),
      .inc  (w_starve_inc),
      .clr  (st_req_ready_o),
      .sat  (w_sat)
   );

   // Handshake outputs are gated by rstn so nothing leaks while reset is held.
   assign req_valid_o     = rstn & w_req_valid;
   assign w_accept        = req_valid_o & req_ready_i;
   assign st_req_ready_o  = w_accept & (w_op == LSU_OP_STORE);
   assign ld_req_ready_o  = w_accept & (w_op == LSU_OP_LOAD);

   assign req_opcode_o    = w_op;
   assign req_size_o      = (w_op == LSU_OP_STORE) ? st_req_size_i : ld_req_size_i;
   assign req_addr_o      = (w_op == LSU_OP_STORE) ? st_req_addr_i : ld_req_addr_i;
   assign req_data_o      = (w_op == LSU_OP_STORE) ? st_req_data_i : '0;

   assign resp_ready_o    = rstn & (w_wait | (r_state == DRAIN));
   assign ld_resp_valid_o = rstn & w_wait & resp_valid_i & ~flush_i;
   assign ld_resp_data_o  = resp_data_i;
   assign busy_o          = rstn & ~w_idle;

endmodule

`default_nettype wire

// File: tb/tb_lsu_dcache_arb.sv
// ============================================================================
// Module      : tb_lsu_dcache_arb
// Description : Directed scoreboard bench for the LSU dcache arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_dcache_arb;
   import lsu_arb_pkg::*;

   localparam int VA = 39;
   localparam int XL = 64;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          flush_i = 1'b0;
   logic          ld_req_valid_i = 1'b0;
   logic          ld_req_ready_o;
   logic [1:0]    ld_req_size_i = SIZE_D;
   logic [VA-1:0] ld_req_addr_i = '0;
   logic          ld_resp_valid_o;
   logic [XL-1:0] ld_resp_data_o;
   logic          st_req_valid_i = 1'b0;
   logic          st_req_ready_o;
   logic [1:0]    st_req_size_i = SIZE_D;
   logic [VA-1:0] st_req_addr_i = '0;
   logic [XL-1:0] st_req_data_i = '0;
   logic          req_valid_o;
   logic          req_ready_i = 1'b0;
   logic          req_opcode_o;
   logic [1:0]    req_size_o;
   logic [VA-1:0] req_addr_o;
   logic [XL-1:0] req_data_o;
   logic          resp_valid_i = 1'b0;
   logic [XL-1:0] resp_data_i = '0;
   logic          resp_ready_o;
   logic          busy_o;

   lsu_dcache_arb #(
      .VIRTUAL_ADDR_LEN (VA),
      .XLEN             (XL),
      .STARVE_LIMIT     (4),
      .STARVE_CNT_W     (3)
   ) dut (
      .clk             (clk),
      .rstn            (rstn),
      .flush_i         (flush_i),
      .ld_req_valid_i  (ld_req_valid_i),
      .ld_req_ready_o  (ld_req_ready_o),
      .ld_req_size_i   (ld_req_size_i),
      .ld_req_addr_i   (ld_req_addr_i),
      .ld_resp_valid_o (ld_resp_valid_o),
      .ld_resp_data_o  (ld_resp_data_o),
      .st_req_valid_i  (st_req_valid_i),
      .st_req_ready_o  (st_req_ready_o),
      .st_req_size_i   (st_req_size_i),
      .st_req_addr_i   (st_req_addr_i),
      .st_req_data_i   (st_req_data_i),
      .req_valid_o     (req_valid_o),
      .req_ready_i     (req_ready_i),
      .req_opcode_o    (req_opcode_o),
      .req_size_o      (req_size_o),
      .req_addr_o      (req_addr_o),
      .req_data_o      (req_data_o),
      .resp_valid_i    (resp_valid_i),
      .resp_data_i     (resp_data_i),
      .resp_ready_o    (resp_ready_o),
      .busy_o          (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          op;
      logic [VA-1:0] addr;
      logic [XL-1:0] data;
   } req_t;

   req_t          req_q[$];
   logic [XL-1:0] resp_q[$];
   int            n_pass = 0;
   int            n_fail = 0;
   int            n_total = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      chk(tag, {63'd0, obs}, {63'd0, exp});
   endtask

   function automatic req_t mk_req(input logic op, input logic [VA-1:0] a, input logic [XL-1:0] d);
      req_t r;
      r.op = op;
      r.addr = a;
      r.data = d;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every dcache accept and every load response is popped and compared here.
   always @(negedge clk) begin
      if (rstn && req_valid_o && req_ready_i) begin
         req_t e;
         n_total++;
         assert (req_q.size() > 0) n_pass++;
         else begin
            n_fail++;
            $error("FAIL req_unexpected observed=accept addr=0x%0h expected=no_accept", req_addr_o);
         end
         if (req_q.size() > 0) begin
            e = req_q.pop_front();
            chk1("req_opcode", req_opcode_o, e.op);
            chk("req_addr", 64'(req_addr_o), 64'(e.addr));
            chk("req_data", req_data_o, e.data);
         end
      end
      if (ld_resp_valid_o) begin
         n_total++;
         assert (resp_q.size() > 0) n_pass++;
         else begin
            n_fail++;
            $error("FAIL resp_unexpected observed=0x%0h expected=no_response", ld_resp_data_o);
         end
         if (resp_q.size() > 0) chk("ld_resp_data", ld_resp_data_o, resp_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset: outputs forced low even with a request presented.
      st_req_valid_i = 1'b1;
      req_ready_i    = 1'b1;
      #2;
      chk1("rst_req_valid", req_valid_o, 1'b0);
      chk1("rst_st_ready", st_req_ready_o, 1'b0);
      chk1("rst_busy", busy_o, 1'b0);
      st_req_valid_i = 1'b0;
      req_ready_i    = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
      tick();

      // Store only, zero-cycle issue.
      st_req_valid_i = 1'b1;
      st_req_addr_i  = 39'h1000;
      st_req_data_i  = 64'hDEAD;
      req_ready_i    = 1'b1;
      req_q.push_back(mk_req(LSU_OP_STORE, 39'h1000, 64'hDEAD));
      #2;
      chk1("st_req_valid", req_valid_o, 1'b1);
      chk1("st_opcode", req_opcode_o, 1'b1);
      chk("st_addr", 64'(req_addr_o), 64'h1000);
      chk1("st_ready", st_req_ready_o, 1'b1);
      chk1("st_ld_ready", ld_req_ready_o, 1'b0);
      tick();
      st_req_valid_i = 1'b0;
      req_ready_i    = 1'b0;
      #2;
      chk1("st_stays_idle", busy_o, 1'b0);

      // Load with two stalled cycles, then a delayed response.
      tick();
      ld_req_valid_i = 1'b1;
      ld_req_addr_i  = 39'h2008;
      req_q.push_back(mk_req(LSU_OP_LOAD, 39'h2008, 64'h0));
      #2;
      chk1("ld_idle_valid", req_valid_o, 1'b1);
      chk1("ld_idle_opcode", req_opcode_o, 1'b0);
      chk1("ld_idle_noready", ld_req_ready_o, 1'b0);
      tick();
      #2;
      chk1("hold_busy", busy_o, 1'b1);
      chk1("hold_valid", req_valid_o, 1'b1);
      chk("hold_addr", 64'(req_addr_o), 64'h2008);
      tick();
      req_ready_i = 1'b1;
      #2;
      chk1("hold_ld_ready", ld_req_ready_o, 1'b1);
      tick();
      ld_req_valid_i = 1'b0;
      req_ready_i    = 1'b0;
      #2;
      chk1("wait_busy", busy_o, 1'b1);
      chk1("wait_resp_ready", resp_ready_o, 1'b1);
      chk1("wait_no_req", req_valid_o, 1'b0);
      tick();
      tick();
      resp_valid_i = 1'b1;
      resp_data_i  = 64'h55;
      resp_q.push_back(64'h55);
      #2;
      chk1("ld_resp_valid", ld_resp_valid_o, 1'b1);
      tick();
      resp_valid_i = 1'b0;
      #2;
      chk1("ld_back_idle", busy_o, 1'b0);

      // Starvation: four load wins, then the store must win.
      tick();
      ld_req_valid_i = 1'b1;
      ld_req_addr_i  = 39'h3000;
      st_req_valid_i = 1'b1;
      st_req_addr_i  = 39'h4000;
      st_req_data_i  = 64'hBEEF;
      req_ready_i    = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_q.push_back(mk_req(LSU_OP_LOAD, 39'h3000, 64'h0));
         resp_q.push_back(64'h100 + 64'(i));
         #2;
         chk1("starve_ld_win", ld_req_ready_o, 1'b1);
         chk1("starve_st_lose", st_req_ready_o, 1'b0);
         tick();
         resp_valid_i = 1'b1;
         resp_data_i  = 64'h100 + 64'(i);
         #2;
         chk1("starve_wait_no_req", req_valid_o, 1'b0);
         tick();
         resp_valid_i = 1'b0;
      end
      req_q.push_back(mk_req(LSU_OP_STORE, 39'h4000, 64'hBEEF));
      #2;
      chk1("starve_st_win", st_req_ready_o, 1'b1);
      chk1("starve_ld_wait", ld_req_ready_o, 1'b0);
      chk1("starve_opcode", req_opcode_o, 1'b1);
      tick();
      req_q.push_back(mk_req(LSU_OP_LOAD, 39'h3000, 64'h0));
      resp_q.push_back(64'h200);
      #2;
      chk1("starve_cleared_ld_win", ld_req_ready_o, 1'b1);
      tick();
      ld_req_valid_i = 1'b0;
      st_req_valid_i = 1'b0;
      resp_valid_i   = 1'b1;
      resp_data_i    = 64'h200;
      tick();
      resp_valid_i = 1'b0;
      req_ready_i  = 1'b0;

      // Flush while waiting: response must be drained and dropped.
      ld_req_valid_i = 1'b1;
      ld_req_addr_i  = 39'h5000;
      req_ready_i    = 1'b1;
      req_q.push_back(mk_req(LSU_OP_LOAD, 39'h5000, 64'h0));
      #2;
      chk1("fw_ld_ready", ld_req_ready_o, 1'b1);
      tick();
      ld_req_valid_i = 1'b0;
      req_ready_i    = 1'b0;
      flush_i        = 1'b1;
      #2;
      chk1("fw_busy", busy_o, 1'b1);
      tick();
      flush_i = 1'b0;
      #2;
      chk1("drain_busy", busy_o, 1'b1);
      chk1("drain_resp_ready", resp_ready_o, 1'b1);
      tick();
      resp_valid_i = 1'b1;
      resp_data_i  = 64'h77;
      #2;
      chk1("drain_no_resp", ld_resp_valid_o, 1'b0);
      tick();
      resp_valid_i = 1'b0;
      #2;
      chk1("drain_back_idle", busy_o, 1'b0);

      // Flush in HOLD with a load grant while a store waits.
      tick();
      ld_req_valid_i = 1'b1;
      ld_req_addr_i  = 39'h6000;
      st_req_valid_i = 1'b1;
      st_req_addr_i  = 39'h7000;
      st_req_data_i  = 64'h1234;
      #2;
      chk1("fh_ld_granted", req_opcode_o, 1'b0);
      tick();
      flush_i     = 1'b1;
      req_ready_i = 1'b1;
      #2;
      chk1("fh_valid_drop", req_valid_o, 1'b0);
      chk1("fh_no_ld_ready", ld_req_ready_o, 1'b0);
      tick();
      flush_i        = 1'b0;
      ld_req_valid_i = 1'b0;
      req_q.push_back(mk_req(LSU_OP_STORE, 39'h7000, 64'h1234));
      #2;
      chk1("fh_st_issue", st_req_ready_o, 1'b1);
      chk("fh_st_addr", 64'(req_addr_o), 64'h7000);
      tick();
      st_req_valid_i = 1'b0;
      req_ready_i    = 1'b0;

      // Asynchronous reset in WAIT_RESP.
      ld_req_valid_i = 1'b1;
      ld_req_addr_i  = 39'h8000;
      req_ready_i    = 1'b1;
      req_q.push_back(mk_req(LSU_OP_LOAD, 39'h8000, 64'h0));
      #2;
      chk1("ar_ld_ready", ld_req_ready_o, 1'b1);
      tick();
      ld_req_valid_i = 1'b0;
      req_ready_i    = 1'b0;
      st_req_valid_i = 1'b1;
      #2;
      chk1("ar_wait_busy", busy_o, 1'b1);
      #1;
      rstn         = 1'b0;
      resp_valid_i = 1'b1;
      #1;
      chk1("ar_req_valid", req_valid_o, 1'b0);
      chk1("ar_busy", busy_o, 1'b0);
      chk1("ar_resp_ready", resp_ready_o, 1'b0);
      chk1("ar_ld_resp", ld_resp_valid_o, 1'b0);
      st_req_valid_i = 1'b0;
      tick();
      tick();
      rstn        = 1'b1;
      resp_data_i = 64'h99;
      #2;
      chk1("ar_stray_resp", ld_resp_valid_o, 1'b0);
      chk1("ar_stray_ready", resp_ready_o, 1'b0);
      tick();
      resp_valid_i = 1'b0;
      #2;
      chk1("ar_idle_after", busy_o, 1'b0);

      tick();
      chk("req_q_drained", 64'(req_q.size()), 64'd0);
      chk("resp_q_drained", 64'(resp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lsu_dcache_arb.md
Name: lsu_dcache_arb

Overview:
- Shares the single dcache request/response port between the LSU load pipe and the store-commit path.
- Arbitrates between the two requesters and holds the grant until the dcache accepts the request.
- Tracks the one outstanding load until its response returns, and routes that response back to the load pipe.
- Sits between the LSU control unit / store buffer and the dcache; provides load-over-store priority with bounded store starvation and flush-kill of in-flight loads.

Parameters:
- VIRTUAL_ADDR_LEN, 39, request address width
- XLEN, 64, data width
- STARVE_LIMIT, 4, consecutive lost arbitrations after which the store wins
- STARVE_CNT_W, 3, starvation counter width; must hold STARVE_LIMIT

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; kills load traffic
- ld_req_valid_i  in  1  load request valid
- ld_req_ready_o  out  1  load request accepted by dcache
- ld_req_size_i  in  2  load size
- ld_req_addr_i  in  VIRTUAL_ADDR_LEN  load address
- ld_resp_valid_o  out  1  load data valid
- ld_resp_data_o  out  XLEN  load data
- st_req_valid_i  in  1  store request valid
- st_req_ready_o  out  1  store request accepted by dcache
- st_req_size_i  in  2  store size
- st_req_addr_i  in  VIRTUAL_ADDR_LEN  store address
- st_req_data_i  in  XLEN  store data
- req_valid_o  out  1  dcache request valid
- req_ready_i  in  1  dcache request ready
- req_opcode_o  out  1  0 = load, 1 = store
- req_size_o  out  2  size to dcache
- req_addr_o  out  VIRTUAL_ADDR_LEN  address to dcache
- req_data_o  out  XLEN  store data to dcache
- resp_valid_i  in  1  dcache response valid
- resp_data_i  in  XLEN  dcache response data
- resp_ready_o  out  1  response accept
- busy_o  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values: state = IDLE, grant = load, starve_cnt = 0.
- While rstn = 0, all valid/ready outputs are forced to 0: req_valid_o, ld_req_ready_o, st_req_ready_o, ld_resp_valid_o, resp_ready_o, busy_o.
- Requester rule: a requester holds valid and its fields stable until its ready is seen. The arbiter never re-arbitrates while a request is presented and unaccepted.
- States:
  - IDLE: arbitrate. Dcache fields come from the winner through a combinational path (zero-cycle issue).
  - HOLD: request presented, not yet accepted. Registered grant selects the fields.
  - WAIT_RESP: load accepted; waiting for its response.
  - DRAIN: load killed by flush; waiting to discard its response.
- IDLE arbitration:
  - Load is eligible only if ld_req_valid_i = 1 and flush_i = 0.
  - Only one requester eligible: it wins.
  - Both eligible: load wins, unless starve_cnt == STARVE_LIMIT, in which case the store wins.
  - No winner: req_valid_o = 0.
- IDLE transitions:
  - Winner is a store and req_ready_i = 1: st_req_ready_o = 1, stay in IDLE.
  - Winner is a load and req_ready_i = 1: ld_req_ready_o = 1, go to WAIT_RESP.
  - req_ready_i = 0: latch grant, go to HOLD.
- HOLD:
  - req_valid_o = 1, fields from the granted requester.
  - On req_ready_i: store goes to IDLE; load goes to WAIT_RESP. The matching *_req_ready_o pulses that cycle.
  - flush_i with a load grant: req_valid_o = 0 that cycle, go to IDLE, no ld_req_ready_o. The dcache tolerates retraction under flush.
  - flush_i with a store grant: ignored.
- WAIT_RESP:
  - resp_ready_o = 1.
  - ld_resp_valid_o = resp_valid_i & ~flush_i, and ld_resp_data_o = resp_data_i, same cycle.
  - On resp_valid_i go to IDLE.
  - flush_i without a response: go to DRAIN.
  - flush_i together with resp_valid_i: response dropped, go to IDLE.
  - No new request issues in WAIT_RESP; both ready outputs are 0.
- DRAIN:
  - resp_ready_o = 1, ld_resp_valid_o = 0.
  - On resp_valid_i go to IDLE. A further flush_i is ignored.
- resp_valid_i in IDLE/HOLD: ignored; resp_ready_o = 0.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each IDLE cycle in which st_req_valid_i = 1 and the store is not the winner.
  - Clears on st_req_ready_o.
  - Holds in every other state.
- Outputs: req_opcode_o equals the winner/grant opcode. req_data_o carries st_req_data_i for stores and is 0 for loads.
- busy_o = (state != IDLE).

Decomposition:
- Package lsu_arb_pkg holds:
  - state encoding IDLE/HOLD/WAIT_RESP/DRAIN
  - LSU_OP_LOAD = 0 and LSU_OP_STORE = 1
  - size encodings B/H/W/D = 0..3
- One sub-module, lsu_arb_starve_ctr: the saturating counter, with inc, clr, and a sat output.

Test Plan:
- Store only: st_req_valid_i = 1, addr 0x1000, data 0xDEAD, req_ready_i = 1 → same cycle req_valid_o = 1, req_opcode_o = 1, req_addr_o = 0x1000, st_req_ready_o = 1; state stays IDLE.
- Load with delayed response: ld addr 0x2008, req_ready_i = 0 for 2 cycles, then 1; resp_valid_i 3 cycles later with 0x55 → grant held through HOLD, busy_o = 1, ld_resp_valid_o = 1 with ld_resp_data_o = 0x55, then IDLE.
- Starvation: both valid continuously, req_ready_i = 1, each load response returns in 1 cycle → after 4 load wins the store wins on the 5th arbitration and starve_cnt returns to 0.
- Flush in WAIT_RESP: load accepted, flush_i pulse, resp_valid_i 2 cycles later → state DRAIN, ld_resp_valid_o stays 0, IDLE after the response.
- Flush in HOLD (load) with a store pending: req_valid_o drops, no ld_req_ready_o; next cycle the store issues.
- Asynchronous reset asserted mid-WAIT_RESP → all outputs 0 immediately, state IDLE, starve_cnt = 0; after release, a stray resp_valid_i is ignored.
